reg_file_ab_latch: RTL and testbench

- Multicycle datapath register file, directly downstream of the 4:1 write-data select stage.
- Write port consumes the selected write-back word: ALUOut, MDR, PC+4 or immediate.
- Two read ports feed the A/B operand latches on LatchAB, for the next-state ALU cycles.
- Debug read port and a saturating write counter support bench/board inspection.

---
 rtl/reg_file_ab_latch.sv | 87 ++++++++
 tb/tb_reg_file_ab_latch.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_ab_latch.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_ab_latch
// Brief    : Register file with A/B operand latches, debug read port and a
//            saturating write counter. Optional macro REGFILE_WR_BYPASS_EN
//            forwards same-cycle write data into A/B.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_ab_latch #(
   parameter int                 DATA_W  = 32,
   parameter int                 ADDR_W  = 5,
   parameter logic [DATA_W-1:0]  SP_INIT = 32'h0000_3FFC,
   parameter int                 CNT_W   = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_reg_write,
   input  logic [ADDR_W-1:0] i_write_reg,
   input  logic [DATA_W-1:0] i_write_data,
   input  logic [ADDR_W-1:0] i_read_reg1,
   input  logic [ADDR_W-1:0] i_read_reg2,
   input  logic              i_latch_ab,
   output logic [DATA_W-1:0] o_a,
   output logic [DATA_W-1:0] o_b,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   output logic [DATA_W-1:0] o_dbg_data,
   output logic [CNT_W-1:0]  o_write_count
);

   localparam int              c_DEPTH  = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] c_SP_IDX = ADDR_W'(29);

   logic [DATA_W-1:0] r_mem [c_DEPTH];
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_wr_en;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;

   assign w_wr_en = i_reg_write && (i_write_reg != '0);

   always_comb begin
      w_rd1 = (i_read_reg1 == '0) ? '0 : r_mem[i_read_reg1];
      w_rd2 = (i_read_reg2 == '0) ? '0 : r_mem[i_read_reg2];
`ifdef REGFILE_WR_BYPASS_EN
      // w_wr_en already excludes index 0, so $0 can never be forwarded
      if (w_wr_en && (i_write_reg == i_read_reg1)) w_rd1 = i_write_data;
      if (w_wr_en && (i_write_reg == i_read_reg2)) w_rd2 = i_write_data;
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < c_DEPTH; i++)
            r_mem[i] <= (ADDR_W'(i) == c_SP_IDX) ? SP_INIT : '0;
      end else if (w_wr_en) begin
         r_mem[i_write_reg] <= i_write_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_a <= '0;
         r_b <= '0;
      end else if (i_latch_ab) begin
         r_a <= w_rd1;
         r_b <= w_rd2;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (w_wr_en && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_a           = r_a;
   assign o_b           = r_b;
   assign o_dbg_data    = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];
   assign o_write_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_ab_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_ab_latch
// Brief    : Self-checking bench; random and directed stimulus against an
//            array-based reference model. Honours REGFILE_WR_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_ab_latch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [4:0]  rd1;
   logic [4:0]  rd2;
   logic        latch;
   logic [4:0]  dbg_addr;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] dbg;
   logic [15:0] cnt;
   logic [31:0] a_s;
   logic [31:0] b_s;
   logic [31:0] dbg_s;
   logic [3:0]  cnt4;

   always #5 clk = ~clk;

   reg_file_ab_latch u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_reg_write(we), .i_write_reg(wa),
      .i_write_data(wd), .i_read_reg1(rd1), .i_read_reg2(rd2),
      .i_latch_ab(latch), .o_a(a), .o_b(b), .i_dbg_addr(dbg_addr),
      .o_dbg_data(dbg), .o_write_count(cnt)
   );

   reg_file_ab_latch #(.CNT_W(4)) u_sat (
      .i_clk(clk), .i_rst_n(rst_n), .i_reg_write(we), .i_write_reg(wa),
      .i_write_data(wd), .i_read_reg1(rd1), .i_read_reg2(rd2),
      .i_latch_ab(latch), .o_a(a_s), .o_b(b_s), .i_dbg_addr(dbg_addr),
      .o_dbg_data(dbg_s), .o_write_count(cnt4)
   );

   logic [31:0] m_mem [32];
   logic [31:0] m_a;
   logic [31:0] m_b;
   int          m_cnt;
   int          m_cnt4;
   int          total = 0;
   int          bad   = 0;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      m_mem[29] = 32'h0000_3FFC;
      m_a = 0; m_b = 0; m_cnt = 0; m_cnt4 = 0;
   endtask

   task automatic idle_inputs();
      we = 0; wa = 0; wd = 0; rd1 = 0; rd2 = 0; latch = 0;
   endtask

   // One clock: model applies the edge's effect, then return at the negedge
   task automatic tick();
      logic [31:0] na, nb;
      @(posedge clk);
      if (rst_n) begin
         if (latch) begin
            na = m_mem[rd1];
            nb = m_mem[rd2];
`ifdef REGFILE_WR_BYPASS_EN
            if (we && wa != 0 && wa == rd1) na = wd;
            if (we && wa != 0 && wa == rd2) nb = wd;
`endif
            m_a = na;
            m_b = nb;
         end
         if (we && wa != 0) begin
            m_mem[wa] = wd;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
         end
      end
      @(negedge clk);
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_n = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      apply_reset();
      dbg_addr = 29; #1;
      total++; if (a !== 32'h0) begin bad++; $display("FAIL reset_A: got %h want 0", a); end
      total++; if (b !== 32'h0) begin bad++; $display("FAIL reset_B: got %h want 0", b); end
      total++; if (cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt: got %h want 0", cnt); end
      total++; if (dbg !== 32'h0000_3FFC) begin bad++; $display("FAIL reset_sp: got %h want 00003ffc", dbg); end
      dbg_addr = 5; #1;
      total++; if (dbg !== 32'h0) begin bad++; $display("FAIL reset_r5: got %h want 0", dbg); end
      @(negedge clk);
   endtask

   task automatic test_basic();
      idle_inputs();
      we = 1; wa = 8; wd = 32'hDEAD_BEEF; tick();
      wa = 9; wd = 32'h1234_5678; tick();
      idle_inputs(); latch = 1; rd1 = 8; rd2 = 9; tick();
      latch = 0;
      total++; if (a !== 32'hDEAD_BEEF) begin bad++; $display("FAIL basic_A: got %h want deadbeef", a); end
      total++; if (b !== 32'h1234_5678) begin bad++; $display("FAIL basic_B: got %h want 12345678", b); end
      total++; if (cnt !== 16'd2) begin bad++; $display("FAIL basic_cnt: got %0d want 2", cnt); end
   endtask

   task automatic test_zero_reg();
      idle_inputs();
      we = 1; wa = 0; wd = 32'hFFFF_FFFF; tick();
      idle_inputs(); latch = 1; rd1 = 0; rd2 = 0; tick();
      latch = 0; dbg_addr = 0; #1;
      total++; if (a !== 32'h0) begin bad++; $display("FAIL zero_A: got %h want 0", a); end
      total++; if (dbg !== 32'h0) begin bad++; $display("FAIL zero_dbg: got %h want 0", dbg); end
      total++; if (cnt !== 16'd2) begin bad++; $display("FAIL zero_cnt: got %0d want 2", cnt); end
   endtask

   task automatic test_hazard();
      logic [31:0] exp_a;
`ifdef REGFILE_WR_BYPASS_EN
      exp_a = 32'h2;
`else
      exp_a = 32'h1;
`endif
      idle_inputs();
      we = 1; wa = 10; wd = 32'h1; tick();
      wd = 32'h2; latch = 1; rd1 = 10; rd2 = 10; tick();
      idle_inputs(); dbg_addr = 10; #1;
      total++; if (a !== exp_a) begin bad++; $display("FAIL hazard_A: got %h want %h", a, exp_a); end
      total++; if (b !== exp_a) begin bad++; $display("FAIL hazard_B: got %h want %h", b, exp_a); end
      total++; if (dbg !== 32'h2) begin bad++; $display("FAIL hazard_dbg: got %h want 2", dbg); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         we    = 1'($urandom);
         wa    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         wd    = $urandom;
         latch = 1'($urandom);
         rd1   = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 7));
         rd2   = ($urandom_range(0, 3) == 0) ? rd1 : 5'($urandom);
         tick();
         dbg_addr = 5'($urandom); #1;
         total++; if (a !== m_a) begin bad++; $display("FAIL rand_A[%0d]: got %h want %h", n, a, m_a); end
         total++; if (b !== m_b) begin bad++; $display("FAIL rand_B[%0d]: got %h want %h", n, b, m_b); end
         total++; if (dbg !== m_mem[dbg_addr]) begin bad++; $display("FAIL rand_dbg[%0d]: got %h want %h", n, dbg, m_mem[dbg_addr]); end
         total++; if (cnt !== 16'(m_cnt)) begin bad++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", n, cnt, m_cnt); end
         total++; if (cnt4 !== 4'(m_cnt4)) begin bad++; $display("FAIL rand_cnt4[%0d]: got %0d want %0d", n, cnt4, m_cnt4); end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      we = 1; wa = 7; wd = 32'h0000_ABCD; tick();
      idle_inputs(); latch = 1; rd1 = 7; rd2 = 29; tick();
      total++; if (a !== 32'h0000_ABCD) begin bad++; $display("FAIL mid_pre_A: got %h want 0000abcd", a); end
      we = 1; wa = 7; wd = 32'h5555_5555; latch = 1; rd1 = 7; rd2 = 7; dbg_addr = 7;
      #2 rst_n = 0;
      #1;
      total++; if (a !== 32'h0) begin bad++; $display("FAIL mid_A: got %h want 0", a); end
      total++; if (b !== 32'h0) begin bad++; $display("FAIL mid_B: got %h want 0", b); end
      total++; if (dbg !== 32'h0) begin bad++; $display("FAIL mid_r7: got %h want 0", dbg); end
      dbg_addr = 29; #1;
      total++; if (dbg !== 32'h0000_3FFC) begin bad++; $display("FAIL mid_sp: got %h want 00003ffc", dbg); end
      @(posedge clk); @(negedge clk);
      idle_inputs(); rst_n = 1; model_reset();
      dbg_addr = 7; #1;
      total++; if (dbg !== 32'h0) begin bad++; $display("FAIL mid_lost_wr: got %h want 0", dbg); end
      total++; if (cnt !== 16'h0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", cnt); end
   endtask

   task automatic test_saturation();
      apply_reset();
      for (int n = 0; n < 20; n++) begin
         we = 1; wa = 1; wd = 32'(n); tick();
      end
      idle_inputs(); tick();
      total++; if (cnt4 !== 4'hF) begin bad++; $display("FAIL sat_cnt4: got %h want f", cnt4); end
      total++; if (cnt !== 16'd20) begin bad++; $display("FAIL sat_cnt16: got %0d want 20", cnt); end
      we = 1; wa = 3; wd = 32'h77; tick(); idle_inputs();
      total++; if (cnt4 !== 4'hF) begin bad++; $display("FAIL sat_hold: got %h want f", cnt4); end
   endtask

   initial begin
      idle_inputs();
      dbg_addr = 0;
      rst_n = 0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_basic();
      test_zero_reg();
      test_hazard();
      test_random();
      test_reset_mid();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
